gs232c_fetch_window_ctrl: RTL and testbench

Sequencer for the k-word fetch-window selector. It buffers one 2^N-word fetch line and walks a word pointer across it. Each cycle it presents up to K consecutive words to the decode/issue stage and advances by however many words the consumer accepts. It sits between the I-cache return path and the decode/issue stage, and instantiates gs232c_sel_k_words_n_m (n=N, k=K, w=W, circular=0) as its datapath.

---
 rtl/gs232c_fetch_window_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_gs232c_fetch_window_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gs232c_fetch_window_ctrl.sv
// gs232c_fetch_window_ctrl
//
// Purpose:
//   This is the fetch-window sequencer between the I-cache return path and
//   decode/issue. It holds one 2^N-word fetch line and walks a word pointer
//   across it. Each cycle it presents up to K consecutive words and advances
//   by the number of words the consumer takes.
//   The datapath is gs232c_sel_k_words_n_m, used in non-circular mode and
//   defined first in this file.
//
// Optional feature:
//   GS232C_FWC_PREFETCH_EN adds a one-entry next-line register, so that
//   back-to-back lines stream without a bubble. When the macro is undefined,
//   the block has a single line buffer.
//
// Ports:
//   clock       sole clock, rising edge
//   reset       asynchronous, active-high reset
//   flush       discards the current line and any buffered next line (redirect)
//   line_valid  a fetch line is offered
//   line_ready  the controller accepts a line this cycle
//   line_data   fetch line; word j is at [j*W +: W]
//   line_start  index of the first useful word of the offered line
//   out_valid   out_words/out_count are meaningful
//   out_count   number of valid words in out_words (0 when idle)
//   out_words   window; word 0 is at [W-1:0], words past out_count are zero
//   out_take    words consumed this cycle (sampled only when out_valid)
//   proto_err   sticky: out_take exceeded out_count; cleared only by reset

// Selects k consecutive w-bit words starting at word 'start' of a 2^n-word line.
module gs232c_sel_k_words_n_m #(
  parameter int unsigned n        = 4,
  parameter int unsigned k        = 4,
  parameter int unsigned w        = 32,
  parameter bit          circular = 1'b0
) (
  input  logic [(w<<n)-1:0] line,
  input  logic [n-1:0]      start,
  output logic [w*k-1:0]    words
);

  localparam int unsigned NW = 1 << n;
  localparam int unsigned SW = n + 1;

  logic [w-1:0] lw [NW];
  logic [SW-1:0] sum;

  for (genvar j = 0; j < int'(NW); j++) begin : g_split
    assign lw[j] = line[j*w +: w];
  end

  // sum[n] marks a word past the line end: zero it, or wrap it when circular.
  always_comb begin
    words = '0;
    sum   = '0;
    for (int i = 0; i < int'(k); i++) begin
      sum = {1'b0, start} + SW'(i);
      if (!sum[n] || circular) begin
        words[i*w +: w] = lw[sum[n-1:0]];
      end
    end
  end

endmodule

module gs232c_fetch_window_ctrl #(
  parameter  int unsigned N  = 4,
  parameter  int unsigned K  = 4,
  parameter  int unsigned W  = 32,
  localparam int unsigned CW = $clog2(K + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              line_valid,
  output logic              line_ready,
  input  logic [(W<<N)-1:0] line_data,
  input  logic [N-1:0]      line_start,
  output logic              out_valid,
  output logic [CW-1:0]     out_count,
  output logic [W*K-1:0]    out_words,
  input  logic [CW-1:0]     out_take,
  output logic              proto_err
);

  localparam int unsigned WORDS = 1 << N;
  localparam int unsigned PW    = N + 1;
  localparam int unsigned LW    = W << N;

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t         state;
  logic [PW-1:0]  ptr;
  logic [LW-1:0]  line_q;

  logic [PW-1:0]  remaining;
  logic [CW-1:0]  avail;
  logic [CW-1:0]  eff;
  logic [PW-1:0]  ptr_sum;
  logic           take_over;
  logic           line_done;
  logic           load;
  logic           load_cur;
  logic [W*K-1:0] sel_words;

`ifdef GS232C_FWC_PREFETCH_EN
  logic           next_valid;
  logic [LW-1:0]  next_data;
  logic [N-1:0]   next_start;
  logic           load_next;
  logic           promote;
`endif

  gs232c_sel_k_words_n_m #(
    .n        (N),
    .k        (K),
    .w        (W),
    .circular (1'b0)
  ) u_sel (
    .line  (line_q),
    .start (ptr[N-1:0]),
    .words (sel_words)
  );

  // Window view, take accounting and line hand-off decisions.
  always_comb begin
    remaining = PW'(WORDS) - ptr;
    avail     = (remaining < PW'(K)) ? CW'(remaining) : CW'(K);
    out_valid = (state == DRAIN);
    out_count = out_valid ? avail : '0;
    out_words = out_valid ? sel_words : '0;
    // Overdraw is clamped to what is on offer and flagged.
    take_over = out_valid && (out_take > avail);
    eff       = !out_valid ? '0 : (take_over ? avail : out_take);
    ptr_sum   = ptr + PW'(eff);
    line_done = out_valid && (ptr_sum == PW'(WORDS));
`ifdef GS232C_FWC_PREFETCH_EN
    line_ready = !reset && !flush && !next_valid;
    load       = line_valid && line_ready;
    promote    = !flush && line_done && next_valid;
    // A line that arrives as the current one finishes bypasses the next-line slot.
    load_cur   = load && ((state == EMPTY) || line_done);
    load_next  = load && (state == DRAIN) && !line_done;
`else
    line_ready = !reset && !flush && (state == EMPTY);
    load       = line_valid && line_ready;
    load_cur   = load;
`endif
  end

  // Sequencer state, pointer and sticky protocol flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      ptr       <= '0;
      proto_err <= 1'b0;
`ifdef GS232C_FWC_PREFETCH_EN
      next_valid <= 1'b0;
`endif
    end else if (flush) begin
      state <= EMPTY;
      ptr   <= '0;
`ifdef GS232C_FWC_PREFETCH_EN
      next_valid <= 1'b0;
`endif
    end else begin
      if (take_over) begin
        proto_err <= 1'b1;
      end
      if (load_cur) begin
        state <= DRAIN;
        ptr   <= {1'b0, line_start};
`ifdef GS232C_FWC_PREFETCH_EN
      end else if (promote) begin
        state <= DRAIN;
        ptr   <= {1'b0, next_start};
`endif
      end else if (line_done) begin
        state <= EMPTY;
        ptr   <= '0;
      end else begin
        ptr <= ptr_sum;
      end
`ifdef GS232C_FWC_PREFETCH_EN
      if (load_next) begin
        next_valid <= 1'b1;
      end else if (promote) begin
        next_valid <= 1'b0;
      end
`endif
    end
  end

  // Line storage carries no reset; the state register qualifies it.
  always_ff @(posedge clock) begin
    if (load_cur) begin
      line_q <= line_data;
`ifdef GS232C_FWC_PREFETCH_EN
    end else if (promote) begin
      line_q <= next_data;
`endif
    end
`ifdef GS232C_FWC_PREFETCH_EN
    if (load_next) begin
      next_data  <= line_data;
      next_start <= line_start;
    end
`endif
  end

endmodule

// File: tb/tb_gs232c_fetch_window_ctrl.sv
// Testbench for gs232c_fetch_window_ctrl (N=4, K=4, W=32).
// A word-level reference model holds lines as word arrays plus a pointer,
// and predicts every output each cycle. Directed steps are followed by a
// randomized phase. The model follows GS232C_FWC_PREFETCH_EN when defined.
module tb_gs232c_fetch_window_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned K  = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 3;
  localparam int unsigned LW = W << N;
  localparam int          NW = 16;
`ifdef GS232C_FWC_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset;
  logic           flush;
  logic           line_valid;
  logic           line_ready;
  logic [LW-1:0]  line_data;
  logic [N-1:0]   line_start;
  logic           out_valid;
  logic [CW-1:0]  out_count;
  logic [W*K-1:0] out_words;
  logic [CW-1:0]  out_take;
  logic           proto_err;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  bit          m_cv, m_nv, m_perr;
  int          m_ptr, m_nstart;
  logic [W-1:0] m_cur [NW];
  logic [W-1:0] m_nxt [NW];

  always #5 clock = ~clock;

  gs232c_fetch_window_ctrl #(.N(N), .K(K), .W(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .line_data  (line_data),
    .line_start (line_start),
    .out_valid  (out_valid),
    .out_count  (out_count),
    .out_words  (out_words),
    .out_take   (out_take),
    .proto_err  (proto_err)
  );

  function automatic logic [LW-1:0] mk_line(input logic [W-1:0] base);
    logic [LW-1:0] v;
    for (int j = 0; j < NW; j++) v[j*W +: W] = base + W'(j);
    return v;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Predicts all outputs from the model state and the current inputs.
  task automatic check_outputs(input string tag);
    int ecnt;
    logic [W*K-1:0] ew;
    bit erdy;
    ecnt = 0;
    ew   = '0;
    if (m_cv) ecnt = (NW - m_ptr < K) ? NW - m_ptr : K;
    for (int i = 0; i < ecnt; i++) ew[i*W +: W] = m_cur[m_ptr + i];
    erdy = (reset === 1'b0) && (flush === 1'b0) && (PF ? !m_nv : !m_cv);
    check({tag, ".out_valid"},  out_valid,  m_cv);
    check({tag, ".out_count"},  out_count,  ecnt);
    check({tag, ".out_words"},  out_words,  ew);
    check({tag, ".line_ready"}, line_ready, erdy);
    check({tag, ".proto_err"},  proto_err,  m_perr);
  endtask

  task automatic model_load_cur();
    for (int j = 0; j < NW; j++) m_cur[j] = line_data[j*W +: W];
    m_ptr = int'(line_start);
    m_cv  = 1'b1;
  endtask

  // One clock edge of the reference model, using the inputs applied in this cycle.
  task automatic model_update();
    bit rdy, acc, done;
    int cnt, eff;
    rdy  = !flush && (PF ? !m_nv : !m_cv);
    acc  = line_valid && rdy;
    done = 1'b0;
    if (flush) begin
      m_cv = 1'b0; m_nv = 1'b0; m_ptr = 0;
      return;
    end
    if (m_cv) begin
      cnt = (NW - m_ptr < K) ? NW - m_ptr : K;
      if (int'(out_take) > cnt) begin
        m_perr = 1'b1;
        eff    = cnt;
      end else begin
        eff = int'(out_take);
      end
      m_ptr += eff;
      done = (m_ptr == NW);
    end
    if (done) begin
      if (m_nv) begin
        m_cur = m_nxt; m_ptr = m_nstart; m_nv = 1'b0;
      end else if (acc) begin
        model_load_cur();
      end else begin
        m_cv = 1'b0; m_ptr = 0;
      end
    end else if (acc) begin
      if (!m_cv) begin
        model_load_cur();
      end else begin
        for (int j = 0; j < NW; j++) m_nxt[j] = line_data[j*W +: W];
        m_nstart = int'(line_start);
        m_nv     = 1'b1;
      end
    end
  endtask

  // Drive one cycle at the falling edge, check at +1, then advance the model at the rising edge.
  task automatic cyc(input string tag, input bit f, input bit lv, input logic [LW-1:0] d,
                     input int st, input int tk);
    flush      = f;
    line_valid = lv;
    line_data  = d;
    line_start = N'(st);
    out_take   = CW'(tk);
    #1;
    check_outputs(tag);
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic do_reset(input string tag);
    reset      = 1'b1;
    flush      = 1'b0;
    line_valid = 1'b0;
    out_take   = '0;
    m_cv = 1'b0; m_nv = 1'b0; m_perr = 1'b0; m_ptr = 0;
    #1;
    check_outputs(tag);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic [LW-1:0] l1, l2, lr;
    l1 = mk_line(32'h1000);
    l2 = mk_line(32'h2000);
    reset = 1'b1; flush = 1'b0; line_valid = 1'b0; line_data = '0;
    line_start = '0; out_take = '0;
    @(negedge clock);
    do_reset("reset");

    // 1: full line from word 0, four beats of four
    cyc("t1_load", 0, 1, l1, 0, 0);
    check("t1_beat0", out_words, {32'h1003, 32'h1002, 32'h1001, 32'h1000});
    for (int b = 0; b < 4; b++) cyc("t1_beat", 0, 0, '0, 0, 4);
    cyc("t1_idle", 0, 0, '0, 0, 0);

    // 2: start near line end; words beyond the end are zero
    cyc("t2_load", 0, 1, l1, 14, 0);
    check("t2_count", out_count, 2);
    check("t2_words", out_words, {32'h0, 32'h0, 32'h100F, 32'h100E});
    cyc("t2_take", 0, 0, '0, 0, 2);
    check("t2_empty", out_valid, 0);

    // 3: partial takes
    cyc("t3_load", 0, 1, l1, 0, 0);
    cyc("t3_take1", 0, 0, '0, 0, 1);
    check("t3_word0a", out_words[31:0], 32'h1001);
    cyc("t3_take3", 0, 0, '0, 0, 3);
    check("t3_word0b", out_words[31:0], 32'h1004);
    check("t3_count", out_count, 4);
    for (int b = 0; b < 3; b++) cyc("t3_drain", 0, 0, '0, 0, 4);

    // 4: overdraw at ptr=13 ends the line and sets the sticky flag
    cyc("t4_load", 0, 1, l1, 13, 0);
    check("t4_count", out_count, 3);
    cyc("t4_over", 0, 0, '0, 0, 4);
    check("t4_perr", proto_err, 1);
    check("t4_done", out_valid, 0);
    cyc("t4_flush", 1, 0, '0, 0, 0);
    check("t4_perr_flush", proto_err, 1);
    do_reset("t4_reset");
    check("t4_perr_reset", proto_err, 0);

    // 5: flush beats a take and an offered line in the same cycle
    cyc("t5_load", 0, 1, l1, 0, 0);
    cyc("t5_hold", 0, 0, '0, 0, 0);
    cyc("t5_flush", 1, 1, l2, 0, 2);
    flush = 1'b0; line_valid = 1'b0; out_take = '0;
    #1;
    check("t5_valid", out_valid, 0);
    check("t5_ready", line_ready, 1);

    // 6: second line offered while draining
    cyc("t6_load", 0, 1, l1, 8, 0);
    cyc("t6_offer", 0, 1, l2, 3, 4);
    cyc("t6_last", 0, 1, l2, 3, 4);
`ifdef GS232C_FWC_PREFETCH_EN
    check("t6_nobubble", out_valid, 1);
    check("t6_word0", out_words[31:0], 32'h2003);
    cyc("t6_next", 0, 0, '0, 0, 0);
`else
    check("t6_bubble", out_valid, 0);
    cyc("t6_next", 0, 1, l2, 3, 0);
    check("t6_word0", out_words[31:0], 32'h2003);
`endif
    for (int b = 0; b < 4; b++) cyc("t6_drain", 0, 0, '0, 0, 4);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      if ((c % 150) == 149) begin
        do_reset("rnd_reset");
      end else begin
        for (int j = 0; j < NW; j++) lr[j*W +: W] = W'($urandom);
        cyc("rnd", ($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1, lr,
            int'($urandom_range(0, 15)),
            ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
